// File: rtl/param_pipe_reg.sv
// Multi-stage valid/ready register pipeline with bubble collapse, synchronous flush
// and a registered occupancy count; drop-in successor to the single enabled D-FF.
module param_pipe_reg #(
  parameter int unsigned            DATA_WIDTH  = 32,
  parameter int unsigned            STAGES      = 3,
  parameter logic [DATA_WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_flush,
  input  logic                           i_valid,
  output logic                           o_ready,
  input  logic [DATA_WIDTH-1:0]          i_data,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic [DATA_WIDTH-1:0]          o_data,
  output logic [$clog2(STAGES+1)-1:0]    o_count
);

  localparam int unsigned CW = $clog2(STAGES + 1);

  logic [STAGES-1:0]     r_valid;
  logic [DATA_WIDTH-1:0] r_data [STAGES];
  logic [CW-1:0]         r_count;

  logic [STAGES-1:0]     w_rdy;
  logic [STAGES-1:0]     w_up_valid;
  logic [DATA_WIDTH-1:0] w_up_data [STAGES];
  logic                  w_push;
  logic                  w_pop;

  // rdy[k] = !v[k] | rdy[k+1] unrolled: a stage may load unless it and every
  // stage after it is occupied while the consumer stalls.
  always_comb begin
    logic l_tail_full;
    l_tail_full = 1'b1;
    w_rdy       = '0;
    for (int unsigned j = 0; j < STAGES; j++) begin
      l_tail_full              = l_tail_full & r_valid[STAGES-1-j];
      w_rdy[STAGES-1-j]        = i_ready | !l_tail_full;
    end
  end

  always_comb begin
    w_up_valid    = '0;
    w_up_valid[0] = i_valid;
    w_up_data[0]  = i_data;
    for (int unsigned k = 1; k < STAGES; k++) begin
      w_up_valid[k] = r_valid[k-1];
      w_up_data[k]  = r_data[k-1];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        r_data[k] <= RESET_VALUE;
      end
    end else if (i_flush) begin
      r_valid <= '0;
    end else begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        if (w_rdy[k]) begin
          r_valid[k] <= w_up_valid[k];
          if (w_up_valid[k]) begin
            r_data[k] <= w_up_data[k];
          end
        end
      end
    end
  end

  assign w_push = i_valid & o_ready;
  assign w_pop  = o_valid & i_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_flush) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_ready = w_rdy[0] & !i_flush;
  assign o_valid = r_valid[STAGES-1] & !i_flush;
  assign o_data  = r_data[STAGES-1];
  assign o_count = r_count;

endmodule

// File: tb/tb_param_pipe_reg.sv
// Directed vector table plus hand sequences on an 8-bit 3-stage pipe, then a
// random scoreboard run on 1/2/5-stage instances sharing one stimulus stream.
module tb_param_pipe_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Directed DUT: W=8, S=3
  logic       rst, flush, vin, rdy_in;
  logic [7:0] din;
  logic       ordy, ov;
  logic [7:0] od;
  logic [1:0] cnt;

  param_pipe_reg #(.DATA_WIDTH(8), .STAGES(3), .RESET_VALUE(8'h00)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(vin), .o_ready(ordy),
    .i_data(din), .o_valid(ov), .i_ready(rdy_in), .o_data(od), .o_count(cnt)
  );

  // Random DUTs: W=16, S in {1,2,5}
  localparam int SDEPTH [3] = '{1, 2, 5};
  logic        rrst, rfl, rv, rr;
  logic [15:0] rdat;
  logic        xr [3];
  logic        xv [3];
  logic [15:0] xd [3];
  logic [2:0]  xc [3];
  logic [0:0]  c1;
  logic [1:0]  c2;
  logic [2:0]  c5;

  param_pipe_reg #(.DATA_WIDTH(16), .STAGES(1), .RESET_VALUE(16'hBEEF)) u_s1 (
    .i_clk(clk), .i_rst(rrst), .i_flush(rfl), .i_valid(rv), .o_ready(xr[0]),
    .i_data(rdat), .o_valid(xv[0]), .i_ready(rr), .o_data(xd[0]), .o_count(c1)
  );
  param_pipe_reg #(.DATA_WIDTH(16), .STAGES(2), .RESET_VALUE(16'hBEEF)) u_s2 (
    .i_clk(clk), .i_rst(rrst), .i_flush(rfl), .i_valid(rv), .o_ready(xr[1]),
    .i_data(rdat), .o_valid(xv[1]), .i_ready(rr), .o_data(xd[1]), .o_count(c2)
  );
  param_pipe_reg #(.DATA_WIDTH(16), .STAGES(5), .RESET_VALUE(16'hBEEF)) u_s5 (
    .i_clk(clk), .i_rst(rrst), .i_flush(rfl), .i_valid(rv), .o_ready(xr[2]),
    .i_data(rdat), .o_valid(xv[2]), .i_ready(rr), .o_data(xd[2]), .o_count(c5)
  );

  assign xc[0] = {2'b00, c1};
  assign xc[1] = {1'b0, c2};
  assign xc[2] = c5;

  typedef struct {
    logic       fl;
    logic       vl;
    logic [7:0] d;
    logic       rd;
    logic       erdy;
    logic       eov;
    logic [7:0] eod;
    logic [1:0] ecnt;
  } vec_t;

  vec_t tv [$];

  task automatic add(input int fl, input int vl, input int d, input int rd,
                     input int erdy, input int eov, input int eod, input int ecnt);
    vec_t v;
    v.fl   = (fl != 0);
    v.vl   = (vl != 0);
    v.d    = 8'(d);
    v.rd   = (rd != 0);
    v.erdy = (erdy != 0);
    v.eov  = (eov != 0);
    v.eod  = 8'(eod);
    v.ecnt = 2'(ecnt);
    tv.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  int          mcnt  [3];
  int          wrp   [3];
  int          rdp   [3];
  logic [15:0] sb    [3][16];
  logic        pstall[3];
  logic [15:0] pdata [3];

  initial begin
    rst = 1'b1; flush = 1'b0; vin = 1'b0; rdy_in = 1'b0; din = 8'h00;
    rrst = 1'b1; rfl = 1'b0; rv = 1'b0; rr = 1'b0; rdat = 16'h0000;

    //         fl vl d     rd  rdy ov od    cnt
    // stream
    add(0, 1, 'h01, 1,  1, 0, 'h00, 0);
    add(0, 1, 'h02, 1,  1, 0, 'h00, 1);
    add(0, 1, 'h03, 1,  1, 0, 'h00, 2);
    add(0, 1, 'h04, 1,  1, 1, 'h01, 3);
    add(0, 1, 'h05, 1,  1, 1, 'h02, 3);
    add(0, 0, 'h00, 1,  1, 1, 'h03, 3);
    add(0, 0, 'h00, 1,  1, 1, 'h04, 2);
    add(0, 0, 'h00, 1,  1, 1, 'h05, 1);
    add(0, 0, 'h00, 0,  1, 0, 'h05, 0);
    // backpressure
    add(0, 1, 'hA1, 0,  1, 0, 'h05, 0);
    add(0, 1, 'hA2, 0,  1, 0, 'h05, 1);
    add(0, 1, 'hA3, 0,  1, 0, 'h05, 2);
    add(0, 1, 'hA4, 0,  0, 1, 'hA1, 3);
    add(0, 1, 'hA4, 1,  1, 1, 'hA1, 3);
    add(0, 0, 'h00, 0,  0, 1, 'hA2, 3);
    add(0, 0, 'h00, 1,  1, 1, 'hA2, 3);
    add(0, 0, 'h00, 1,  1, 1, 'hA3, 2);
    add(0, 0, 'h00, 1,  1, 1, 'hA4, 1);
    add(0, 0, 'h00, 0,  1, 0, 'hA4, 0);
    // bubble collapse
    add(0, 1, 'h5A, 0,  1, 0, 'hA4, 0);
    add(0, 0, 'h00, 0,  1, 0, 'hA4, 1);
    add(0, 0, 'h00, 0,  1, 0, 'hA4, 1);
    add(0, 1, 'h5B, 0,  1, 1, 'h5A, 1);
    add(0, 1, 'h5C, 0,  1, 1, 'h5A, 2);
    add(0, 0, 'h00, 0,  0, 1, 'h5A, 3);
    add(0, 0, 'h00, 1,  1, 1, 'h5A, 3);
    add(0, 0, 'h00, 1,  1, 1, 'h5B, 2);
    add(0, 0, 'h00, 1,  1, 1, 'h5C, 1);
    add(0, 0, 'h00, 1,  1, 0, 'h5C, 0);
    // flush
    add(0, 1, 'h11, 0,  1, 0, 'h5C, 0);
    add(0, 1, 'h22, 0,  1, 0, 'h5C, 1);
    add(0, 1, 'h33, 0,  1, 0, 'h5C, 2);
    add(1, 1, 'h44, 1,  0, 0, 'h11, 3);
    add(0, 0, 'h00, 1,  1, 0, 'h11, 0);
    add(0, 1, 'h55, 1,  1, 0, 'h11, 0);
    add(0, 0, 'h00, 1,  1, 0, 'h11, 1);
    add(0, 0, 'h00, 1,  1, 0, 'h11, 1);
    add(0, 0, 'h00, 1,  1, 1, 'h55, 1);
    add(0, 0, 'h00, 0,  1, 0, 'h55, 0);

    // reset state, no clock edge yet
    #2;
    chk("rst_valid", 32'(ov), 32'(0));
    chk("rst_data", 32'(od), 32'(8'h00));
    chk("rst_count", 32'(cnt), 32'(0));
    chk("rst_ready", 32'(ordy), 32'(1));
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (tv[i]) begin
      flush = tv[i].fl; vin = tv[i].vl; din = tv[i].d; rdy_in = tv[i].rd;
      #4;
      chk($sformatf("tbl%0d_ready", i), 32'(ordy), 32'(tv[i].erdy));
      chk($sformatf("tbl%0d_valid", i), 32'(ov), 32'(tv[i].eov));
      chk($sformatf("tbl%0d_data", i), 32'(od), 32'(tv[i].eod));
      chk($sformatf("tbl%0d_count", i), 32'(cnt), 32'(tv[i].ecnt));
      @(posedge clk); #1;
    end

    // long gapless stream: 3-edge latency, 1 beat per cycle
    for (int k = 1; k <= 24; k++) begin
      flush = 1'b0; rdy_in = 1'b1; vin = (k <= 20); din = 8'(k);
      #4;
      chk($sformatf("strm%0d_valid", k), 32'(ov), 32'((k >= 4 && k <= 23) ? 1 : 0));
      if (k >= 4 && k <= 23) chk($sformatf("strm%0d_data", k), 32'(od), 32'(k - 3));
      chk($sformatf("strm%0d_count", k), 32'(cnt),
          32'((k <= 21) ? ((k - 1 < 3) ? k - 1 : 3) : 24 - k));
      @(posedge clk); #1;
    end

    // async reset of a full pipe between edges
    for (int j = 0; j < 3; j++) begin
      vin = 1'b1; din = 8'(8'h0A + j); rdy_in = 1'b0;
      @(posedge clk); #1;
    end
    vin = 1'b0;
    #1;
    chk("prerst_count", 32'(cnt), 32'(3));
    chk("prerst_data", 32'(od), 32'(8'h0A));
    #1 rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(ov), 32'(0));
    chk("midrst_count", 32'(cnt), 32'(0));
    chk("midrst_data", 32'(od), 32'(8'h00));
    chk("midrst_ready", 32'(ordy), 32'(1));
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("postrst_ready", 32'(ordy), 32'(1));
    for (int j = 0; j < 4; j++) begin
      rdy_in = 1'b1;
      @(posedge clk); #4;
      chk($sformatf("postrst%0d_valid", j), 32'(ov), 32'(0));
    end

    // random scoreboard run on S=1,2,5
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rnd%0d_rst_data", i), 32'(xd[i]), 32'(16'hBEEF));
      chk($sformatf("rnd%0d_rst_valid", i), 32'(xv[i]), 32'(0));
      mcnt[i] = 0; wrp[i] = 0; rdp[i] = 0; pstall[i] = 1'b0; pdata[i] = 16'h0000;
    end
    @(posedge clk); #1;
    rrst = 1'b0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      rfl  = ($urandom_range(0, 39) == 0);
      rv   = ($urandom_range(0, 3) != 0);
      rr   = ($urandom_range(0, 2) != 0);
      rdat = 16'($urandom);
      #4;
      for (int i = 0; i < 3; i++) begin
        if (rfl) begin
          chk("rnd_flush_ready", 32'(xr[i]), 32'(0));
          chk("rnd_flush_valid", 32'(xv[i]), 32'(0));
        end else begin
          chk("rnd_ready", 32'(xr[i]), 32'(((mcnt[i] < SDEPTH[i]) || rr) ? 1 : 0));
          if (mcnt[i] == 0) chk("rnd_valid_empty", 32'(xv[i]), 32'(0));
          if (pstall[i]) begin
            chk("rnd_stall_valid", 32'(xv[i]), 32'(1));
            chk("rnd_stall_data", 32'(xd[i]), 32'(pdata[i]));
          end
          if (xv[i] && rr && mcnt[i] > 0)
            chk("rnd_order", 32'(xd[i]), 32'(sb[i][rdp[i]]));
        end
        chk("rnd_count", 32'(xc[i]), 32'(mcnt[i]));
        if (rfl) begin
          mcnt[i] = 0; rdp[i] = wrp[i]; pstall[i] = 1'b0;
        end else begin
          if (xv[i] && rr && mcnt[i] > 0) begin
            rdp[i] = (rdp[i] + 1) % 16; mcnt[i]--;
          end
          if (rv && xr[i] && mcnt[i] < 16) begin
            sb[i][wrp[i]] = rdat; wrp[i] = (wrp[i] + 1) % 16; mcnt[i]++;
          end
          pstall[i] = xv[i] & !rr;
          pdata[i]  = xd[i];
        end
      end
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
